// File: rtl/addr_xlate_unit.sv
// addr_xlate_unit
//   Translates a 32-bit virtual address into a PADDR_W-bit physical address
//   by matching it against NUM_REGIONS inclusive base/limit windows. The unit
//   checks each access for natural alignment and for writes to read-only
//   regions. It returns the result through a single registered valid/ready
//   stage. It also keeps a sticky record of the first fault and a saturating
//   count of faults.
//
// Ports
//   clk, rst          clock (rising edge), synchronous active-high reset
//   req_valid/ready   request handshake; req_ready = !rsp_valid || rsp_ready
//   req_vaddr/write/size
//                     virtual address, store flag, size (0 b, 1 h, 2 w, 3 rsvd)
//   rsp_valid/ready   response handshake
//   rsp_paddr         translated address, 0 when the request faulted
//   rsp_region        index of the hit region, 0 on a miss
//   rsp_fault/cause   fault flag and cause (1 unmapped, 2 misaligned, 3 write to RO)
//   fault_clr         clears the sticky fault record and the counter
//   fault_pend/vaddr/cause
//                     sticky record of the first fault since the last clear
//   fault_count       number of accepted faults, saturates at 255
module addr_xlate_unit #(
    parameter int                         PADDR_W      = 13,
    parameter int                         NUM_REGIONS  = 3,
    parameter logic [32*NUM_REGIONS-1:0]  REGION_BASE  = {32'hFFFF_0000, 32'h1001_0000, 32'h0040_0000},
    parameter logic [32*NUM_REGIONS-1:0]  REGION_LIMIT = {32'hFFFF_000F, 32'h1001_0FFF, 32'h0040_1FFF},
    parameter logic [32*NUM_REGIONS-1:0]  REGION_PBASE = {32'h0, 32'h0, 32'h0},
    parameter logic [NUM_REGIONS-1:0]     RO_MASK      = 3'b001,
    parameter bit                         ALIGN_CHECK  = 1'b1,
    localparam int                        REG_W        = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [31:0]        req_vaddr,
    input  logic               req_write,
    input  logic [1:0]         req_size,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [PADDR_W-1:0] rsp_paddr,
    output logic [REG_W-1:0]   rsp_region,
    output logic               rsp_fault,
    output logic [1:0]         rsp_cause,
    input  logic               fault_clr,
    output logic               fault_pend,
    output logic [31:0]        fault_vaddr,
    output logic [1:0]         fault_cause,
    output logic [7:0]         fault_count
);

    localparam logic [1:0] CAUSE_NONE     = 2'd0;
    localparam logic [1:0] CAUSE_UNMAPPED = 2'd1;
    localparam logic [1:0] CAUSE_MISALIGN = 2'd2;
    localparam logic [1:0] CAUSE_RO       = 2'd3;

    logic               rsp_valid_q, rsp_valid_d;
    logic [PADDR_W-1:0] rsp_paddr_q, rsp_paddr_d;
    logic [REG_W-1:0]   rsp_region_q, rsp_region_d;
    logic               rsp_fault_q, rsp_fault_d;
    logic [1:0]         rsp_cause_q, rsp_cause_d;
    logic               fault_pend_q, fault_pend_d;
    logic [31:0]        fault_vaddr_q, fault_vaddr_d;
    logic [1:0]         fault_cause_q, fault_cause_d;
    logic [7:0]         fault_count_q, fault_count_d;

    logic               hit;
    logic [REG_W-1:0]   hit_idx;
    logic               hit_ro;
    logic [PADDR_W-1:0] hit_paddr;
    logic               misaligned;
    logic [1:0]         cause_c;
    logic               accept;

    // Scan from the highest index down so that the lowest hitting region
    // is the last one written and therefore wins on overlap.
    always_comb begin
        hit       = 1'b0;
        hit_idx   = '0;
        hit_ro    = 1'b0;
        hit_paddr = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (req_vaddr >= REGION_BASE[32*i +: 32] && req_vaddr <= REGION_LIMIT[32*i +: 32]) begin
                hit       = 1'b1;
                hit_idx   = REG_W'(i);
                hit_ro    = RO_MASK[i];
                hit_paddr = PADDR_W'(req_vaddr - REGION_BASE[32*i +: 32] + REGION_PBASE[32*i +: 32]);
            end
        end
    end

    always_comb begin
        misaligned = (req_size == 2'd3);
        if (ALIGN_CHECK) begin
            misaligned = misaligned
                       || (req_size == 2'd1 && req_vaddr[0])
                       || (req_size == 2'd2 && req_vaddr[1:0] != 2'b00);
        end
        if (misaligned) begin
            cause_c = CAUSE_MISALIGN;
        end else if (!hit) begin
            cause_c = CAUSE_UNMAPPED;
        end else if (req_write && hit_ro) begin
            cause_c = CAUSE_RO;
        end else begin
            cause_c = CAUSE_NONE;
        end
    end

    assign req_ready = !rsp_valid_q || rsp_ready;
    assign accept    = req_valid && req_ready;

    always_comb begin
        rsp_valid_d   = rsp_valid_q;
        rsp_paddr_d   = rsp_paddr_q;
        rsp_region_d  = rsp_region_q;
        rsp_fault_d   = rsp_fault_q;
        rsp_cause_d   = rsp_cause_q;
        fault_pend_d  = fault_pend_q;
        fault_vaddr_d = fault_vaddr_q;
        fault_cause_d = fault_cause_q;
        fault_count_d = fault_count_q;

        if (accept) begin
            rsp_valid_d  = 1'b1;
            rsp_fault_d  = (cause_c != CAUSE_NONE);
            rsp_cause_d  = cause_c;
            rsp_region_d = hit_idx;
            rsp_paddr_d  = (cause_c != CAUSE_NONE) ? '0 : hit_paddr;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end

        if (fault_clr) begin
            fault_pend_d  = 1'b0;
            fault_vaddr_d = '0;
            fault_cause_d = CAUSE_NONE;
            fault_count_d = '0;
        end

        // The clear is applied first, so a fault accepted in the same cycle
        // lands in a freshly cleared record.
        if (accept && cause_c != CAUSE_NONE) begin
            if (!fault_pend_d) begin
                fault_pend_d  = 1'b1;
                fault_vaddr_d = req_vaddr;
                fault_cause_d = cause_c;
            end
            if (fault_count_d != 8'hFF) begin
                fault_count_d = fault_count_d + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q   <= 1'b0;
            rsp_paddr_q   <= '0;
            rsp_region_q  <= '0;
            rsp_fault_q   <= 1'b0;
            rsp_cause_q   <= CAUSE_NONE;
            fault_pend_q  <= 1'b0;
            fault_vaddr_q <= '0;
            fault_cause_q <= CAUSE_NONE;
            fault_count_q <= '0;
        end else begin
            rsp_valid_q   <= rsp_valid_d;
            rsp_paddr_q   <= rsp_paddr_d;
            rsp_region_q  <= rsp_region_d;
            rsp_fault_q   <= rsp_fault_d;
            rsp_cause_q   <= rsp_cause_d;
            fault_pend_q  <= fault_pend_d;
            fault_vaddr_q <= fault_vaddr_d;
            fault_cause_q <= fault_cause_d;
            fault_count_q <= fault_count_d;
        end
    end

    assign rsp_valid   = rsp_valid_q;
    assign rsp_paddr   = rsp_paddr_q;
    assign rsp_region  = rsp_region_q;
    assign rsp_fault   = rsp_fault_q;
    assign rsp_cause   = rsp_cause_q;
    assign fault_pend  = fault_pend_q;
    assign fault_vaddr = fault_vaddr_q;
    assign fault_cause = fault_cause_q;
    assign fault_count = fault_count_q;

endmodule
